seq_detector_prog: RTL

//  Programmable serial sequence detector. This is the parametrised successor to the fixed
//  5-state detector FSMs. A pattern of 1..MAX_LEN bits is loaded at run time. Overlapping
//  or non-overlapping detection is selected at load time. The block emits a one-cycle

---
 rtl/seq_detector_prog_if.sv | 28 ++
 rtl/seq_detector_prog.sv | 124 ++++++++++++
 2 files changed

// File: rtl/seq_detector_prog_if.sv
// Bundles configuration, serial input and status signals of the programmable sequence detector.
// master drives configuration and data; slave is the detector itself.
interface seq_detector_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               i;
    logic               out;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;
    logic               armed;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, i,
        input  out, match_count, cfg_err, armed
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, i,
        output out, match_count, cfg_err, armed
    );
endinterface

// File: rtl/seq_detector_prog.sv
// Programmable serial sequence detector: runtime pattern of 1..MAX_LEN bits, optional overlap,
// registered one-cycle match pulse one edge after the final bit; saturating match counter; no backpressure.
module seq_detector_prog #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    seq_detector_prog_if.slave bus
);
    typedef enum logic {UNCFG, RUN} state_t;

    state_t state_q, state_d;

    // The oldest history bit can never take part in a future compare, so only MAX_LEN-1 are kept.
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_q, out_d;
    logic               err_q, err_d;

    logic               cfg_legal;
    logic [MAX_LEN-1:0] hist_new;
    logic [LEN_W-1:0]   fill_new;
    logic [MAX_LEN-1:0] len_mask;
    logic               match;

    assign cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
    assign hist_new  = {hist_q, bus.i};
    assign fill_new  = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);

    always_comb begin
        len_mask = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            len_mask[k] = (k < int'(len_q));
        end
    end

    assign match = (fill_new >= len_q) && (((hist_new ^ pat_q) & len_mask) == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= UNCFG;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.cfg_load && cfg_legal) begin
            state_d = RUN;
        end
    end

    always_comb begin
        bus.armed       = (state_q == RUN);
        bus.out         = out_q;
        bus.match_count = cnt_q;
        bus.cfg_err     = err_q;
    end

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        cnt_d  = cnt_q;
        out_d  = 1'b0;
        err_d  = 1'b0;
        if (bus.cfg_load) begin
            // A load cycle never shifts in data, legal or not.
            if (cfg_legal) begin
                pat_d  = bus.cfg_pattern;
                len_d  = bus.cfg_len;
                ovl_d  = bus.cfg_overlap;
                hist_d = '0;
                fill_d = '0;
                cnt_d  = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (state_q == RUN && bus.in_valid) begin
            hist_d = hist_new[MAX_LEN-2:0];
            fill_d = fill_new;
            out_d  = match;
            if (match) begin
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (!ovl_q) begin
                    fill_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= '0;
            len_q  <= '0;
            ovl_q  <= 1'b0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            err_q  <= err_d;
        end
    end
endmodule
